// File: rtl/glb_feeder_pkg.sv
// Shared definitions for the GLB stream feeder: channel FSM encoding, FIFO sizing, channel roles.
package glb_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } feed_state_e;

  localparam int CH_WEIGHT = 0;
  localparam int CH_IFMAP  = 1;
  localparam int CH_PSUM   = 2;

  // Two slots beyond the read latency let one word/cycle flow while the PE pops every cycle.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/glb_feed_ch.sv
// One GLB-to-PE channel: first read 1 cycle after start, first word RD_LAT+2 cycles after start.
// Reads are credit-limited to FIFO space, so pe_ready low stalls issue and never drops data. Stride via GLB_FEEDER_STRIDE_EN.
module glb_feed_ch
  import glb_feeder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic              ch_flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] pe_data,
  output logic              pe_valid,
  input  logic              pe_ready,
  output logic              busy,
  output logic              done
);
  localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

  feed_state_e       state;
  logic [ADDR_W-1:0] addr, step, step_cfg;
  logic [LEN_W-1:0]  remaining;
  logic [RD_LAT-1:0] vld_pipe;
  logic [CW-1:0]     fifo_cnt, inflight;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic              push, pop, drained;

`ifdef GLB_FEEDER_STRIDE_EN
  assign step_cfg = cfg_stride;
`else
  logic unused_stride;
  assign unused_stride = ^cfg_stride;
  assign step_cfg      = ADDR_W'(1);
`endif

  // Credit = FIFO occupancy plus reads still in the latency pipe.
  assign mem_rd_en   = (state == ST_RUN) && (remaining != '0) && !ch_flush &&
                       (({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C);
  assign mem_rd_addr = addr;
  assign push        = vld_pipe[RD_LAT-1];
  assign pe_valid    = (fifo_cnt != '0);
  assign pop         = pe_valid && pe_ready;
  assign pe_data     = pe_valid ? fifo_mem[rd_ptr] : '0;
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_FIN);
  assign drained     = (inflight == '0) &&
                       ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

  always_ff @(posedge clk) begin
    if (rst || ch_flush) begin
      state     <= ST_IDLE;
      addr      <= '0;
      step      <= '0;
      remaining <= '0;
      vld_pipe  <= '0;
      inflight  <= '0;
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      vld_pipe <= RD_LAT'({vld_pipe, mem_rd_en});
      inflight <= inflight + CW'(mem_rd_en) - CW'(push);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (mem_rd_en) begin
        addr      <= addr + step;
        remaining <= remaining - 1'b1;
      end
      case (state)
        ST_IDLE: if (cfg_start) begin
          addr      <= cfg_base_addr;
          remaining <= cfg_len;
          step      <= step_cfg;
          state     <= (cfg_len == '0) ? ST_FIN : ST_RUN;
        end
        ST_RUN:   if (mem_rd_en && (remaining == LEN_W'(1))) state <= ST_DRAIN;
        ST_DRAIN: if (drained) state <= ST_FIN;
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/glb_stream_feeder.sv
// Multi-channel GLB-to-PE streamer: NUM_CH independent glb_feed_ch instances on flattened buses.
// Latency start->first word RD_LAT+2; per-channel valid/ready backpressure; stride via GLB_FEEDER_STRIDE_EN.
module glb_stream_feeder
  import glb_feeder_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        cfg_start,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base_addr,
  input  logic [NUM_CH*LEN_W-1:0]  cfg_len,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_stride,
  input  logic [NUM_CH-1:0]        ch_flush,
  output logic [NUM_CH-1:0]        mem_rd_en,
  output logic [NUM_CH*ADDR_W-1:0] mem_rd_addr,
  input  logic [NUM_CH*DATA_W-1:0] mem_rd_data,
  output logic [NUM_CH*DATA_W-1:0] pe_data,
  output logic [NUM_CH-1:0]        pe_valid,
  input  logic [NUM_CH-1:0]        pe_ready,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    glb_feed_ch #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .RD_LAT (RD_LAT)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start[c]),
      .cfg_base_addr (cfg_base_addr[c*ADDR_W +: ADDR_W]),
      .cfg_len       (cfg_len[c*LEN_W +: LEN_W]),
      .cfg_stride    (cfg_stride[c*ADDR_W +: ADDR_W]),
      .ch_flush      (ch_flush[c]),
      .mem_rd_en     (mem_rd_en[c]),
      .mem_rd_addr   (mem_rd_addr[c*ADDR_W +: ADDR_W]),
      .mem_rd_data   (mem_rd_data[c*DATA_W +: DATA_W]),
      .pe_data       (pe_data[c*DATA_W +: DATA_W]),
      .pe_valid      (pe_valid[c]),
      .pe_ready      (pe_ready[c]),
      .busy          (busy[c]),
      .done          (done[c])
    );
  end

endmodule

// File: tb/tb_glb_stream_feeder.sv
// Directed bench for glb_stream_feeder with a GLB model (mem[i]=i+1, RD_LAT=1) and per-channel scoreboards.
module tb_glb_stream_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg_start = '0, ch_flush = '0, pe_ready = 3'b111;
  logic [23:0] cfg_base_addr = '0, cfg_len = '0, cfg_stride = '0;
  logic [2:0]  mem_rd_en, pe_valid, busy, done;
  logic [23:0] mem_rd_addr;
  logic [47:0] mem_rd_data = '0;
  logic [47:0] pe_data;

  int vectors = 0;
  int errs = 0;
  logic [7:0]  aq [3][$];
  logic [15:0] dq [3][$];
  int          outst [3];
  int          pops [3];
  logic        prev_stall [3];
  logic [15:0] prev_dat [3];

  always #5 clk = ~clk;

  glb_stream_feeder #(.NUM_CH(3), .DATA_W(16), .ADDR_W(8), .LEN_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_len(cfg_len), .cfg_stride(cfg_stride), .ch_flush(ch_flush),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pe_data(pe_data), .pe_valid(pe_valid), .pe_ready(pe_ready), .busy(busy), .done(done)
  );

  // GLB bank model: one-cycle read latency, 8-bit address space.
  always @(posedge clk)
    for (int c = 0; c < 3; c++)
      if (mem_rd_en[c]) mem_rd_data[c*16 +: 16] <= 16'(mem_rd_addr[c*8 +: 8]) + 16'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and protocol monitor: reads vs. expected addresses, pops vs. expected data.
  always @(negedge clk) begin
    logic [7:0]  ea;
    logic [15:0] ed;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        outst[c] = 0; pops[c] = 0; prev_stall[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (ch_flush[c]) begin
          outst[c] = 0;
          prev_stall[c] = 1'b0;
        end else begin
          if (prev_stall[c]) begin
            chk($sformatf("hold_valid ch%0d", c), {31'd0, pe_valid[c]}, 32'd1);
            chk($sformatf("hold_data ch%0d", c), {16'd0, pe_data[c*16 +: 16]}, {16'd0, prev_dat[c]});
          end
          if (mem_rd_en[c]) begin
            chk($sformatf("credit ch%0d", c), {31'd0, outst[c] < 3}, 32'd1);
            if (aq[c].size() != 0) ea = aq[c].pop_front(); else ea = 'x;
            chk($sformatf("rd_addr ch%0d", c), {24'd0, mem_rd_addr[c*8 +: 8]}, {24'd0, ea});
          end
          if (pe_valid[c] && pe_ready[c]) begin
            pops[c]++;
            if (dq[c].size() != 0) ed = dq[c].pop_front(); else ed = 'x;
            chk($sformatf("pe_data ch%0d", c), {16'd0, pe_data[c*16 +: 16]}, {16'd0, ed});
          end
          outst[c] = outst[c] + int'(mem_rd_en[c]) - int'(pe_valid[c] && pe_ready[c]);
          prev_stall[c] = pe_valid[c] && !pe_ready[c];
          prev_dat[c] = pe_data[c*16 +: 16];
        end
      end
    end
  end

  task automatic arm(input int c, input logic [7:0] base, input logic [7:0] len, input logic [7:0] stride);
    logic [7:0] a;
    a = base;
    cfg_base_addr[c*8 +: 8] = base;
    cfg_len[c*8 +: 8] = len;
    cfg_stride[c*8 +: 8] = stride;
    cfg_start[c] = 1'b1;
    for (int i = 0; i < int'(len); i++) begin
      aq[c].push_back(a);
      dq[c].push_back(16'(a) + 16'd1);
`ifdef GLB_FEEDER_STRIDE_EN
      a = a + stride;
`else
      a = a + 8'd1;
`endif
    end
  endtask

  task automatic go();
    @(posedge clk); #1;
    cfg_start = '0;
  endtask

  task automatic wait_done(input int c, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (done[c] !== 1'b1 && n < 300);
    chk({tag, " done"}, {31'd0, done[c]}, 32'd1);
    chk({tag, " busy_at_done"}, {31'd0, busy[c]}, 32'd0);
    chk({tag, " drained"}, dq[c].size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errs %0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    logic [2:0] seen;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_rd_en", {29'd0, mem_rd_en}, 32'd0);
    chk("rst pe_valid", {29'd0, pe_valid}, 32'd0);
    chk("rst busy", {29'd0, busy}, 32'd0);
    chk("rst done", {29'd0, done}, 32'd0);
    chk("rst pe_data", pe_data[31:0], 32'd0);
    chk("rst rd_addr", {8'd0, mem_rd_addr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: ch0 base 0 len 9, continuous ready: cycle-exact latency and throughput
    @(posedge clk); #1;
    arm(0, 8'h00, 8'd9, 8'd0);
    @(negedge clk);
    chk("t1 busy_t0", {31'd0, busy[0]}, 32'd0);
    go();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("t1 rd_en k%0d", k), {31'd0, mem_rd_en[0]}, {31'd0, k <= 9});
      chk($sformatf("t1 valid k%0d", k), {31'd0, pe_valid[0]}, {31'd0, k >= 3 && k <= 11});
      chk($sformatf("t1 busy k%0d", k), {31'd0, busy[0]}, {31'd0, k <= 11});
      chk($sformatf("t1 done k%0d", k), {31'd0, done[0]}, {31'd0, k == 12});
    end
    chk("t1 drained", dq[0].size(), 32'd0);

    // 2: ch1 base 8 len 4, ready pattern 1,0,0,1
    pat = 4'b1001;
    @(posedge clk); #1;
    arm(1, 8'h08, 8'd4, 8'd0);
    go();
    seen = '0;
    for (int k = 0; k < 60 && !seen[1]; k++) begin
      @(posedge clk); #1;
      pe_ready[1] = pat[k % 4];
      @(negedge clk);
      if (done[1]) seen[1] = 1'b1;
    end
    chk("t2 done", {31'd0, seen[1]}, 32'd1);
    chk("t2 drained", dq[1].size(), 32'd0);
    pe_ready = 3'b111;

    // 3: address wrap FE,FF,00,01
    @(posedge clk); #1;
    arm(0, 8'hFE, 8'd4, 8'd0);
    go();
    wait_done(0, "t3");

    // 4: zero length, then start while busy is ignored
    @(posedge clk); #1;
    arm(1, 8'h50, 8'd0, 8'd0);
    go();
    @(negedge clk);
    chk("t4 len0 done", {31'd0, done[1]}, 32'd1);
    chk("t4 len0 busy", {31'd0, busy[1]}, 32'd0);
    chk("t4 len0 rd_en", {31'd0, mem_rd_en[1]}, 32'd0);
    @(posedge clk); #1;
    arm(1, 8'h10, 8'd3, 8'd0);
    go();
    cfg_base_addr[15:8] = 8'h40;
    cfg_len[15:8] = 8'd9;
    cfg_start[1] = 1'b1;
    @(negedge clk);
    chk("t4 busy_on_restart", {31'd0, busy[1]}, 32'd1);
    go();
    wait_done(1, "t4");
    repeat (4) @(negedge clk);
    chk("t4 no_extra_busy", {31'd0, busy[1]}, 32'd0);

    // 5: flush mid-transfer, then clean restart
    @(posedge clk); #1;
    arm(2, 8'h20, 8'd20, 8'd0);
    go();
    n = 0;
    while (pops[2] < 5 && n < 100) begin @(negedge clk); n++; end
    chk("t5 pops_before_flush", {31'd0, pops[2] >= 5}, 32'd1);
    @(posedge clk); #1;
    ch_flush[2] = 1'b1;
    aq[2].delete();
    dq[2].delete();
    @(posedge clk); #1;
    ch_flush[2] = 1'b0;
    @(negedge clk);
    chk("t5 busy_after_flush", {31'd0, busy[2]}, 32'd0);
    chk("t5 valid_after_flush", {31'd0, pe_valid[2]}, 32'd0);
    chk("t5 done_after_flush", {31'd0, done[2]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t5 quiet_valid %0d", k), {31'd0, pe_valid[2]}, 32'd0);
      chk($sformatf("t5 quiet_done %0d", k), {31'd0, done[2]}, 32'd0);
    end
    @(posedge clk); #1;
    arm(2, 8'h00, 8'd2, 8'd0);
    go();
    wait_done(2, "t5 restart");

    // 6: all channels concurrently with stride 3 and random backpressure
    @(posedge clk); #1;
    arm(0, 8'h00, 8'd4, 8'd3);
    arm(1, 8'h10, 8'd4, 8'd3);
    arm(2, 8'h30, 8'd4, 8'd3);
    go();
    seen = '0;
    for (int k = 0; k < 200 && seen != 3'b111; k++) begin
      @(posedge clk); #1;
      pe_ready = 3'($urandom_range(0, 7));
      @(negedge clk);
      seen = seen | done;
    end
    pe_ready = 3'b111;
    chk("t6 all_done", {29'd0, seen}, 32'd7);
    chk("t6 drained0", dq[0].size(), 32'd0);
    chk("t6 drained1", dq[1].size(), 32'd0);
    chk("t6 drained2", dq[2].size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
